// File: rtl/wr_arb_pkg.sv
// Shared FSM state encoding and elaboration-time helpers for the write-engine arbiter.
package wr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/wr_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after i_ptr wins (no latency).
module wr_rr_picker
   import wr_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDW-1:0]     o_idx,
   output logic               o_any
);

   logic [IDW-1:0] w_j;

   // Walk the ring backwards so the candidate closest to i_ptr is written last and wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_j = IDW'((int'(i_ptr) + k) % NUM_REQ);
         if (i_req[w_j]) begin
            o_grant      = '0;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
            o_any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wr_engine_arbiter.sv
// Round-robin share of one single-beat write engine: accept -> start next cycle -> done one cycle after end_of_write.
// Requesters are back-pressured (req_ready low) whenever a write is in flight.
module wr_engine_arbiter
   import wr_arb_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int ADDR_WIDTH     = 33,
   parameter  int DATA_WIDTH     = 256,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int IDW            = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1,
   localparam int CW             = clog2(TIMEOUT_CYCLES)
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              req_done,
   output logic                            eng_start,
   output logic [ADDR_WIDTH-1:0]           eng_addr,
   output logic [DATA_WIDTH-1:0]           eng_data,
   input  logic                            eng_end_of_write,
   output logic                            busy,
   output logic [IDW-1:0]                  grant_id,
   output logic [31:0]                     wr_count,
   output logic                            timeout_err
);

   state_t                r_state, w_next;
   logic [IDW-1:0]        r_rr_ptr, r_grant_id, w_pick_idx;
   logic [NUM_REQ-1:0]    w_pick_oh, r_done;
   logic                  w_pick_any, w_accept;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_start, r_busy, r_timeout;
   logic [CW-1:0]         r_wait_cnt;
   logic [31:0]           r_wr_count;

   wr_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_oh),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_accept  = (r_state == IDLE) && w_pick_any;
   assign req_ready = (r_state == IDLE) ? w_pick_oh : '0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = ISSUE;
         ISSUE:   w_next = WAIT;
         WAIT:    if (eng_end_of_write) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_start    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= '0;
         r_wait_cnt <= '0;
         r_wr_count <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_start <= (w_next == ISSUE);
         r_busy  <= (w_next != IDLE);
         r_done  <= '0;
         if (w_accept) begin
            r_addr     <= req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_data     <= req_data[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_grant_id <= w_pick_idx;
         end
         // Counter saturates at TIMEOUT_CYCLES-1; the flag is raised as it gets there.
         if (r_state == ISSUE) begin
            r_wait_cnt <= '0;
         end else if (r_state == WAIT && !eng_end_of_write &&
                      r_wait_cnt != CW'(TIMEOUT_CYCLES - 1)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 2)) r_timeout <= 1'b1;
         end
         if (r_state == WAIT && eng_end_of_write) begin
            r_done[r_grant_id] <= 1'b1;
            r_wr_count         <= r_wr_count + 32'd1;
         end
         if (r_state == DONE)
            r_rr_ptr <= (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
      end
   end

   assign eng_start   = r_start;
   assign eng_addr    = r_addr;
   assign eng_data    = r_data;
   assign busy        = r_busy;
   assign req_done    = r_done;
   assign grant_id    = r_grant_id;
   assign wr_count    = r_wr_count;
   assign timeout_err = r_timeout;

endmodule
